// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, arbiter state type and burst-length helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Undefined-length INCR reports 0 beats so it never freezes the grant.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:                return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin search starting one past the pointer
module ahb_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx[IDX_W-1:0]]) begin
        gnt_o[idx[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter: round-robin grant with fixed-burst and locked-sequence freeze
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic [3:0]             HMASTER_DATA,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0]             DEF_IDX = 4'(DEFAULT_MASTER);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             ptr_q, ptr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic [3:0]             hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic                   burst_start;

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i   (HBUSREQ),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // A fixed burst starting this edge keeps its current owner instead of rotating.
  assign burst_start = HREADY && (HTRANS == HTRANS_NONSEQ) && (burst_beats(HBURST) >= 5'd4);
  assign arb_gnt     = burst_start ? grant_q : (pick_valid ? pick_gnt : DEF_GNT);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q        <= ARB;
      grant_q        <= DEF_GNT;
      ptr_q          <= DEF_IDX;
      cnt_q          <= 4'd0;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        grant_d = arb_gnt;
        if (!burst_start && pick_valid) ptr_d = oh2idx(16'(pick_gnt));
        // Lock wins over a burst start so a burst inside a lock stays LOCKED.
        if (|(HLOCK & arb_gnt)) begin
          state_d = LOCKED;
          cnt_d   = 4'd0;
        end else if (burst_start) begin
          state_d = BURST;
          cnt_d   = 4'(burst_beats(HBURST) - 5'd1);
        end
      end
      BURST: begin
        if (HREADY) begin
          if (HTRANS == HTRANS_SEQ) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ARB;
          end else if (HTRANS != HTRANS_BUSY) begin
            cnt_d   = 4'd0;
            state_d = ARB;
          end
        end else if (HRESP != HRESP_OKAY) begin
          cnt_d   = 4'd0;
          state_d = ARB;
        end
      end
      LOCKED: begin
        if (HREADY && !(|(HLOCK & grant_q))) state_d = ARB;
      end
      default: begin
        state_d = ARB;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;
    if (HREADY) begin
      hmaster_d      = oh2idx(16'(grant_q));
      hmaster_data_d = hmaster_q;
      hmastlock_d    = |(HLOCK & grant_q);
    end
    HGRANT       = grant_q;
    HMASTER      = hmaster_q;
    HMASTER_DATA = hmaster_data_q;
    HMASTLOCK    = hmastlock_q;
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter against a transaction-level model
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         HCLK;
  logic         HRESET;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [N-1:0] HGRANT;
  logic [3:0]   HMASTER;
  logic [3:0]   HMASTER_DATA;
  logic         HMASTLOCK;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HBUSREQ      (HBUSREQ),
    .HLOCK        (HLOCK),
    .HTRANS       (HTRANS),
    .HBURST       (HBURST),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HGRANT       (HGRANT),
    .HMASTER      (HMASTER),
    .HMASTER_DATA (HMASTER_DATA),
    .HMASTLOCK    (HMASTLOCK)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [N-1:0] gnt;
    logic [3:0]   hm;
    logic [3:0]   hmd;
    logic         ml;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: mode 0 = arbitrating, 1 = fixed burst, 2 = locked
  int m_mode, m_owner, m_last, m_left, m_hm, m_hmd;
  bit m_ml;

  task automatic model_reset();
    m_mode  = 0;
    m_owner = DEF;
    m_last  = DEF;
    m_left  = 0;
    m_hm    = DEF;
    m_hmd   = DEF;
    m_ml    = 1'b0;
  endtask

  task automatic model_edge();
    int  nxt;
    int  b;
    bit  start;
    if (HREADY) begin
      m_hmd = m_hm;
      m_hm  = m_owner;
      m_ml  = HLOCK[m_owner];
    end
    b = int'(HBURST);
    case (m_mode)
      0: begin
        start = HREADY && HTRANS == 2'b10 && b >= 2;
        nxt   = DEF;
        if (start) nxt = m_owner;
        else begin
          for (int k = 1; k <= N; k++) begin
            if (HBUSREQ[(m_last + k) % N]) begin
              nxt    = (m_last + k) % N;
              m_last = nxt;
              break;
            end
          end
        end
        m_owner = nxt;
        if (HLOCK[nxt]) m_mode = 2;
        else if (start) begin
          m_mode = 1;
          m_left = (4 << ((b - 2) / 2)) - 1;
        end
      end
      1: begin
        if (HREADY) begin
          if (HTRANS == 2'b11) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
          end else if (HTRANS != 2'b01) begin
            m_mode = 0;
            m_left = 0;
          end
        end else if (HRESP != 2'b00) begin
          m_mode = 0;
          m_left = 0;
        end
      end
      default: begin
        if (HREADY && !HLOCK[m_owner]) m_mode = 0;
      end
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.gnt = N'(1) << m_owner;
    e.hm  = 4'(m_hm);
    e.hmd = 4'(m_hmd);
    e.ml  = m_ml;
    q.push_back(e);
  endtask

  task automatic step(input bit rst_n_val);
    @(posedge HCLK);
    #1;
    if (HRESET) model_edge();
    HRESET = rst_n_val;
    if (!rst_n_val) model_reset();
    push_exp();
  endtask

  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    HRESP   = rsp;
    step(1'b1);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("HGRANT",       32'(HGRANT),       32'(e.gnt));
        check("HMASTER",      32'(HMASTER),      32'(e.hm));
        check("HMASTER_DATA", 32'(HMASTER_DATA), 32'(e.hmd));
        check("HMASTLOCK",    32'(HMASTLOCK),    32'(e.ml));
      end
    end
  end

  initial begin
    HRESET  = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = 2'b00;
    HBURST  = 3'b000;
    HREADY  = 1'b1;
    HRESP   = 2'b00;
    model_reset();

    // reset then release with no requests
    step(1'b0);
    step(1'b0);
    step(1'b0);
    cyc(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    cyc(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // round-robin rotation
    for (int i = 0; i < 4; i++) cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // fixed INCR4 by master 2
    cyc(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b10, 3'b011, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b0000, 2'b11, 3'b011, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // INCR8 with three wait states mid-burst
    cyc(4'b1111, 4'b0000, 2'b10, 3'b101, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b101, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b101, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b0000, 2'b11, 3'b101, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) cyc(4'b1111, 4'b0000, 2'b11, 3'b101, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // master 1 locked sequence, released after a wait state
    for (int i = 0; i < 6; i++) cyc(4'b1111, 4'b0010, (i % 2 == 0) ? 2'b10 : 2'b11, 3'b001, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // WRAP8 aborted by ERROR during a wait state
    cyc(4'b1111, 4'b0000, 2'b10, 3'b100, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b100, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b100, 1'b0, 2'b01);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // reset in the middle of an INCR16
    cyc(4'b1111, 4'b0000, 2'b10, 3'b111, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00);
    step(1'b0);
    cyc(4'b1111, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00);
    cyc(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      HBUSREQ = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 19) == 0) HLOCK[$urandom_range(0, N - 1)] ^= 1'b1;
      r = $urandom_range(0, 9);
      if (m_mode == 1) HTRANS = (r < 7) ? 2'b11 : (r == 7) ? 2'b01 : (r == 8) ? 2'b00 : 2'b10;
      else             HTRANS = (r < 4) ? 2'b10 : (r < 8) ? 2'b00 : 2'($urandom_range(1, 3));
      if (HTRANS == 2'b10) HBURST = 3'($urandom_range(0, 7));
      HREADY = ($urandom_range(0, 9) < 8);
      HRESP  = (!HREADY && $urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 399) == 0) begin
        step(1'b0);
        step(1'b0);
      end else begin
        step(1'b1);
      end
    end

    @(negedge HCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_MASTERS, default 4, meaning the number of requesting masters (legal range 2..16).
REQ-002 The module SHALL have parameter DEFAULT_MASTER, default 0, meaning the master parked on the bus when no master requests.
REQ-003 The module SHALL have port HCLK  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port HRESET  input  1  meaning reset, asynchronous and active-low.
REQ-005 The module SHALL have port HBUSREQ  input  NUM_MASTERS  meaning per-master bus request.
REQ-006 The module SHALL have port HLOCK  input  NUM_MASTERS  meaning per-master locked-transfer request.
REQ-007 The module SHALL have port HTRANS  input  2  meaning the transfer type of the current address-phase owner.
REQ-008 The module SHALL have port HBURST  input  3  meaning the burst type of the current address-phase owner.
REQ-009 The module SHALL have port HREADY  input  1  meaning the transfer-complete signal from the selected slave.
REQ-010 The module SHALL have port HRESP  input  2  meaning the slave response (OKAY/ERROR/RETRY/SPLIT).
REQ-011 The module SHALL have port HGRANT  output  NUM_MASTERS  meaning one-hot registered grant.
REQ-012 The module SHALL have port HMASTER  output  4  meaning the index of the address-phase owner.
REQ-013 The module SHALL have port HMASTER_DATA  output  4  meaning the index of the data-phase owner, for the write-data mux.
REQ-014 The module SHALL have port HMASTLOCK  output  1  meaning the current address-phase transfer is locked.

Function
REQ-015 HGRANT SHALL be exactly one-hot in every cycle after reset.
REQ-016 The FSM SHALL have states ARB (grant may change), BURST (fixed-length burst in progress, grant frozen) and LOCKED (locked sequence, grant frozen).
REQ-017 In ARB, HGRANT SHALL update at each edge to the round-robin winner among HBUSREQ, searching from index (last granted + 1) mod NUM_MASTERS upward with wrap-around.
REQ-018 In ARB, when HBUSREQ is all zero, HGRANT SHALL select DEFAULT_MASTER, and the round-robin pointer SHALL NOT advance.
REQ-019 A requesting current owner SHALL lose the grant to any other requester in ARB, giving fairness for undefined-length INCR.
REQ-020 When HREADY=1, HMASTER SHALL load the index of HGRANT, HMASTER_DATA SHALL load the previous HMASTER, and HMASTLOCK SHALL load HLOCK[granted index].
REQ-021 When HREADY=0, HMASTER, HMASTER_DATA and HMASTLOCK SHALL hold their values.
REQ-022 ARB->BURST: HREADY=1, HTRANS=NONSEQ and HBURST in {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16}; the beat counter SHALL load the burst length minus 1 (3, 7 or 15).
REQ-023 In BURST, each HREADY=1 edge with HTRANS=SEQ SHALL decrement the counter, and BUSY SHALL hold it.
REQ-024 BURST->ARB SHALL occur at the edge where the counter reaches 0; the grant re-evaluates at the following edge.
REQ-025 BURST->ARB SHALL also occur, with the counter cleared, on early termination: HREADY=1 with HTRANS IDLE or NONSEQ.
REQ-026 BURST->ARB SHALL also occur, with the counter cleared, on HRESP in {ERROR, RETRY, SPLIT} while HREADY=0.
REQ-027 ARB->LOCKED SHALL occur when the granted master has HLOCK=1 at a grant edge.
REQ-028 LOCKED->ARB SHALL occur on the first HREADY=1 edge where HLOCK[owner]=0.
REQ-029 LOCKED SHALL take precedence over BURST, so a fixed burst inside a lock does not leave LOCKED.
REQ-030 A request deasserted while granted SHALL NOT revoke the grant in BURST or LOCKED.

Reset
REQ-031 While HRESET=0, asynchronously: HGRANT = one-hot DEFAULT_MASTER, HMASTER = HMASTER_DATA = DEFAULT_MASTER, HMASTLOCK=0, state=ARB, counter=0, round-robin pointer=DEFAULT_MASTER.
REQ-032 Reset asserted mid-burst or mid-lock SHALL abandon the sequence with no residual state.

Structure
REQ-033 Shared package ahb_pkg SHALL hold: HTRANS, HBURST and HRESP encodings; arb_state_t enum; the burst-length function mapping HBURST to beats.
REQ-034 The round-robin search SHALL be a combinational sub-module ahb_rr_picker (inputs: request vector, pointer; output: one-hot winner, valid).

Verification
REQ-035 Reset scenario: release HRESET with HBUSREQ=0000 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0.
REQ-036 Round-robin scenario: HBUSREQ=1111 held, HTRANS=IDLE, HREADY=1 -> grants rotate 0010, 0100, 1000, 0001 on consecutive edges.
REQ-037 Fixed-burst scenario: master 2 NONSEQ INCR4 then 3 SEQ, HBUSREQ=1111 -> HGRANT=0100 for 4 beats, then 1000 one edge after the last SEQ.
REQ-038 Wait-state scenario: HREADY=0 for 3 cycles mid-INCR8 -> counter and HMASTER hold; HMASTER_DATA lags HMASTER by one HREADY edge.
REQ-039 Lock scenario: master 1 HLOCK=1 across two transfers, others requesting -> HGRANT stays 0010, HMASTLOCK=1; release on first HREADY=1 with HLOCK=0.
REQ-040 Abort scenario: ERROR response with HREADY=0 at beat 2 of WRAP8 -> state returns to ARB, next grant goes to the next requester.
